// File: rtl/int_ctx_stack.sv
// Nested-interrupt context stack: saves {pc, carry, zero} on interrupt entry and restores them on reti.
// Optional per-entry even parity is enabled with `define INT_CTX_PARITY_EN.
module int_ctx_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic            ClkPC,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            c_i,
    input  logic            z_i,
    input  logic            clr_err_i,
    output logic [PC_W-1:0] pc_o,
    output logic            intc_o,
    output logic            intz_o,
    output logic [DW-1:0]   depth_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            ovf_o,
    output logic            udf_o,
    output logic            parity_err_o
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] pc_q [DEPTH];
    logic [DEPTH-1:0] c_q;
    logic [DEPTH-1:0] z_q;
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic             ovf_q;
    logic             udf_q;
    logic             ovf_set;
    logic             udf_set;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             empty;
    logic             full;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(DEPTH));
    assign top_idx = AW'(depth_q - DW'(1));

    // Push+pop on a non-empty stack replaces the top in place (reti with a pending interrupt).
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        depth_d = depth_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (push_i && pop_i && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_i) begin
            if (!full) begin
                wr_en   = 1'b1;
                wr_idx  = AW'(depth_q);
                depth_d = depth_q + DW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (pop_i) begin
            if (!empty) begin
                depth_d = depth_q - DW'(1);
            end else begin
                udf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge ClkPC or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            c_q     <= '0;
            z_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_set | (ovf_q & ~clr_err_i);
            udf_q   <= udf_set | (udf_q & ~clr_err_i);
            if (wr_en) begin
                pc_q[wr_idx] <= pc_i;
                c_q[wr_idx]  <= c_i;
                z_q[wr_idx]  <= z_i;
            end
        end
    end

    assign pc_o    = empty ? '0 : pc_q[top_idx];
    assign intc_o  = empty ? 1'b0 : c_q[top_idx];
    assign intz_o  = empty ? 1'b0 : z_q[top_idx];
    assign depth_o = depth_q;
    assign empty_o = empty;
    assign full_o  = full;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

`ifdef INT_CTX_PARITY_EN
    logic [DEPTH-1:0] par_q;

    // Stored bit makes the XOR over {pc, c, z, par} zero.
    always_ff @(posedge ClkPC or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else if (wr_en) begin
            par_q[wr_idx] <= ^{pc_i, c_i, z_i};
        end
    end

    assign parity_err_o = !empty &
        (^{pc_q[top_idx], c_q[top_idx], z_q[top_idx]} ^ par_q[top_idx]);
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_int_ctx_stack.sv
// Bench for int_ctx_stack: directed nesting scenarios plus random push/pop traffic,
// checked against a queue-based stack model through an expected-response scoreboard.
module tb_int_ctx_stack;

    localparam int PC_W  = 12;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int W     = PC_W + 2 + DW + 5;

    logic            ClkPC = 1'b0;
    logic            rst   = 1'b1;
    logic            push_i = 1'b0;
    logic            pop_i  = 1'b0;
    logic [PC_W-1:0] pc_i   = '0;
    logic            c_i    = 1'b0;
    logic            z_i    = 1'b0;
    logic            clr_err_i = 1'b0;
    logic [PC_W-1:0] pc_o;
    logic            intc_o;
    logic            intz_o;
    logic [DW-1:0]   depth_o;
    logic            empty_o;
    logic            full_o;
    logic            ovf_o;
    logic            udf_o;
    logic            parity_err_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: a plain queue used as a stack, newest at the back.
    logic [PC_W+1:0] m_stk[$];
    logic            m_ovf = 1'b0;
    logic            m_udf = 1'b0;

    int_ctx_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .ClkPC(ClkPC), .rst(rst), .push_i(push_i), .pop_i(pop_i),
        .pc_i(pc_i), .c_i(c_i), .z_i(z_i), .clr_err_i(clr_err_i),
        .pc_o(pc_o), .intc_o(intc_o), .intz_o(intz_o), .depth_o(depth_o),
        .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o), .udf_o(udf_o),
        .parity_err_o(parity_err_o)
    );

    always #5 ClkPC = ~ClkPC;

    function automatic logic [W-1:0] model_vec();
        logic [PC_W+1:0] top;
        int n;
        n   = m_stk.size();
        top = (n > 0) ? m_stk[n-1] : '0;
        return {top, DW'(n), (n == 0), (n == DEPTH), m_ovf, m_udf, 1'b0};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {pc_o, intc_o, intz_o, depth_o, empty_o, full_o, ovf_o, udf_o, parity_err_o};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (pc,c,z,depth,empty,full,ovf,udf,perr)",
                     name, act, exp);
        end
    endtask

    task automatic model_step(input logic pu, input logic po, input logic [PC_W+1:0] ctx,
                              input logic clr);
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (pu && po && m_stk.size() > 0) begin
            void'(m_stk.pop_back());
            m_stk.push_back(ctx);
        end else if (pu) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(ctx);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_udf = 1'b1;
        end
    endtask

    // Driver: one cycle of stimulus, expected post-edge outputs go to the scoreboard.
    task automatic step(input logic pu, input logic po, input logic [PC_W-1:0] pc,
                        input logic c, input logic z, input logic clr);
        @(negedge ClkPC);
        push_i    = pu;
        pop_i     = po;
        pc_i      = pc;
        c_i       = c;
        z_i       = z;
        clr_err_i = clr;
        model_step(pu, po, {pc, c, z}, clr);
        exp_q.push_back(model_vec());
    endtask

    // Monitor: compares after every capturing edge for which an expectation exists.
    always @(posedge ClkPC) begin
        #2;
        if (exp_q.size() > 0) begin
            check("cycle", dut_vec(), exp_q.pop_front());
        end
    end

    initial begin
        repeat (2) @(posedge ClkPC);
        @(negedge ClkPC);
        #1 check("reset_state", dut_vec(), model_vec());
        rst = 1'b0;

        // Single nest then return.
        step(1, 0, 12'h1A5, 1, 0, 0);
        step(0, 1, 12'h000, 0, 0, 0);

        // Fill, overflow, drain.
        step(1, 0, 12'h010, 0, 1, 0);
        step(1, 0, 12'h020, 1, 0, 0);
        step(1, 0, 12'h030, 1, 1, 0);
        step(1, 0, 12'h040, 0, 0, 0);
        step(1, 0, 12'h050, 1, 1, 0);
        step(1, 1, 12'h0CD, 1, 0, 0);
        repeat (4) step(0, 1, 12'h000, 0, 0, 0);

        // Underflow, clear, clear with simultaneous event.
        step(0, 1, 12'h000, 0, 0, 0);
        step(0, 0, 12'h000, 0, 0, 1);
        step(0, 1, 12'h000, 0, 0, 1);
        step(0, 0, 12'h000, 0, 0, 1);

        // Replace-top with entry below intact, and push+pop on empty.
        step(1, 0, 12'h010, 0, 0, 0);
        step(1, 0, 12'h020, 0, 0, 0);
        step(1, 1, 12'h0AB, 1, 1, 0);
        step(0, 1, 12'h000, 0, 0, 0);
        step(0, 1, 12'h000, 0, 0, 0);
        step(1, 1, 12'h03C, 0, 1, 0);

        // Asynchronous reset mid-cycle with three contexts saved.
        step(1, 0, 12'h111, 1, 0, 0);
        step(1, 0, 12'h222, 0, 1, 0);
        @(posedge ClkPC);
        #3;
        push_i = 1'b0;
        pop_i  = 1'b0;
        clr_err_i = 1'b0;
        rst = 1'b1;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1 check("async_reset", dut_vec(), model_vec());
        @(negedge ClkPC);
        rst = 1'b0;

        // Random traffic, biased to visit both full and empty.
        for (int i = 0; i < 600; i++) begin
            logic pu, po, clr;
            int bias;
            bias = ((i / 60) % 2 == 0) ? 65 : 35;
            pu  = ($urandom_range(0, 99) < bias);
            po  = ($urandom_range(0, 99) < (100 - bias));
            clr = ($urandom_range(0, 9) == 0);
            step(pu, po, PC_W'($urandom), 1'($urandom), 1'($urandom), clr);
        end
        step(0, 0, 12'h000, 0, 0, 0);

        repeat (3) @(posedge ClkPC);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d expected=0 pending expectations", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
